apb_i2c_bridge: RTL and testbench

APB completer that gives the CPU-side APB bus register access to the on-chip I2C master. It holds the slave ID, slave memory address and write data, launches one single-byte I2C read or write per START command, and returns read data and completion/error status. It sits between the system APB interconnect and the I2C master's command port, on the same clock domain as the I2C master.

---
 rtl/apb_i2c_bridge_if.sv | 35 +++
 rtl/apb_i2c_bridge.sv | 187 ++++++++++++++++++
 tb/tb_apb_i2c_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_i2c_bridge_if.sv
`default_nettype none
// ============================================================================
// apb_i2c_bridge_if : APB completer bus plus I2C master command port
// Revision 1.0
// ============================================================================
interface apb_i2c_bridge_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  logic       i2c_req;
  logic       i2c_rw;
  logic [7:0] i2c_slave;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_done;
  logic [7:0] i2c_rdata;
  logic       i2c_err;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, i2c_done, i2c_rdata, i2c_err,
    output prdata, pready, pslverr, i2c_req, i2c_rw, i2c_slave, i2c_addr, i2c_wdata
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, i2c_done, i2c_rdata, i2c_err,
    input  prdata, pready, pslverr, i2c_req, i2c_rw, i2c_slave, i2c_addr, i2c_wdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_i2c_bridge.sv
`default_nettype none
// ============================================================================
// apb_i2c_bridge : APB register front-end launching single-byte I2C commands
// Revision 1.0
// ============================================================================
module apb_i2c_bridge #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                reset_n,
  apb_i2c_bridge_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  A_CTRL   = 8'h00;
  localparam logic [7:0]  A_SLV    = 8'h01;
  localparam logic [7:0]  A_MADDR  = 8'h02;
  localparam logic [7:0]  A_WDATA  = 8'h03;
  localparam logic [7:0]  A_RDATA  = 8'h04;
  localparam logic [7:0]  A_STATUS = 8'h05;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  slv_q, slv_d;
  logic [7:0]  maddr_q, maddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  i2c_slave_q, i2c_slave_d;
  logic [7:0]  i2c_addr_q, i2c_addr_d;
  logic [7:0]  i2c_wdata_q, i2c_wdata_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;

  logic        access;
  logic        busy;
  logic        addr_bad;
  logic        cfg_addr;
  logic        wr_bad;
  logic        stall;
  logic        err_acc;
  logic        wr_ok;
  logic        start;
  logic [7:0]  rd_mux;

  // Access decode; an RDATA read is the only access that may insert wait states.
  always_comb begin
    access   = bus.psel & bus.penable;
    busy     = (state_q == ST_REQ);
    addr_bad = (bus.paddr > A_STATUS);
    cfg_addr = (bus.paddr == A_SLV) | (bus.paddr == A_MADDR) | (bus.paddr == A_WDATA);
    wr_bad   = bus.pwrite & ((bus.paddr == A_RDATA) |
                             (busy & (bus.paddr == A_CTRL) & bus.pwdata[0]) |
                             (busy & cfg_addr));
    stall    = access & ~bus.pwrite & (bus.paddr == A_RDATA) & busy;
    err_acc  = access & (addr_bad | wr_bad);
    wr_ok    = access & bus.pwrite & ~err_acc;
    start    = wr_ok & (bus.paddr == A_CTRL) & bus.pwdata[0];
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.paddr)
      A_SLV:    rd_mux = slv_q;
      A_MADDR:  rd_mux = maddr_q;
      A_WDATA:  rd_mux = wdata_q;
      A_RDATA:  rd_mux = rdata_q;
      A_STATUS: rd_mux = {4'b0000, tmo_q, err_q, done_q, busy};
      default:  rd_mux = 8'h00;
    endcase
  end

  assign bus.pready    = ~stall;
  assign bus.pslverr   = err_acc;
  assign bus.prdata    = (access & ~bus.pwrite & ~stall & ~addr_bad) ? rd_mux : 8'h00;
  assign bus.i2c_req   = (state_q == ST_REQ);
  assign bus.i2c_rw    = rw_q;
  assign bus.i2c_slave = i2c_slave_q;
  assign bus.i2c_addr  = i2c_addr_q;
  assign bus.i2c_wdata = i2c_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slv_d       = slv_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    i2c_slave_d = i2c_slave_q;
    i2c_addr_d  = i2c_addr_q;
    i2c_wdata_d = i2c_wdata_q;
    rw_d        = rw_q;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = tmo_q;

    if (wr_ok) begin
      case (bus.paddr)
        A_SLV:    slv_d   = bus.pwdata;
        A_MADDR:  maddr_d = bus.pwdata;
        A_WDATA:  wdata_d = bus.pwdata;
        A_STATUS: begin
          done_d = done_q & ~bus.pwdata[1];
          err_d  = err_q  & ~bus.pwdata[2];
          tmo_d  = tmo_q  & ~bus.pwdata[3];
        end
        default: ;
      endcase
    end

    // Flag sets below come after the W1C clears so a same-cycle set wins.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rw_d        = bus.pwdata[1];
          i2c_slave_d = slv_q;
          i2c_addr_d  = maddr_q;
          i2c_wdata_d = wdata_q;
          done_d      = 1'b0;
          err_d       = 1'b0;
          tmo_d       = 1'b0;
          cnt_d       = 16'd0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.i2c_done) begin
          if (rw_q) begin
            rdata_d = bus.i2c_rdata;
          end
          done_d  = 1'b1;
          if (bus.i2c_err) begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      slv_q       <= 8'h00;
      maddr_q     <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      i2c_slave_q <= 8'h00;
      i2c_addr_q  <= 8'h00;
      i2c_wdata_q <= 8'h00;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slv_q       <= slv_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      i2c_slave_q <= i2c_slave_d;
      i2c_addr_q  <= i2c_addr_d;
      i2c_wdata_q <= i2c_wdata_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_bridge.sv
`default_nettype none
// ============================================================================
// tb_apb_i2c_bridge : randomized scoreboard bench for apb_i2c_bridge
// Revision 1.0
// ============================================================================
module tb_apb_i2c_bridge;
  localparam int TMO = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  apb_i2c_bridge_if bus();

  apb_i2c_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit         is_rd;
    bit         err;
    logic [7:0] rd;
    bit         stall;
  } apb_exp_t;

  typedef struct {
    bit         rw;
    logic [7:0] slv;
    logic [7:0] adr;
    logic [7:0] wd;
    int         len;
  } cmd_exp_t;

  apb_exp_t apb_q[$];
  cmd_exp_t cmd_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference register file: cfg[1..3] = SLV/MADDR/WDATA, flags = {TMO, ERR, DONE}
  logic [7:0] m_cfg [0:3];
  logic [7:0] m_rdata;
  logic [2:0] m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
    m_rdata = 8'h00;
    m_flags = 3'b000;
  endtask

  task automatic apb_xfer(input bit w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1;
    while (!bus.pready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) fail("apb_timeout");
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  // Predict the response of one non-START access from the register-map rules.
  task automatic do_access(input bit w, input logic [7:0] a, input logic [7:0] d, input bit busy);
    apb_exp_t e;
    e.is_rd = !w; e.err = 1'b0; e.rd = 8'h00; e.stall = 1'b0;
    if (a > 8'h05) begin
      e.err = 1'b1;
    end else if (w) begin
      if (a == 8'h04) e.err = 1'b1;
      else if (a >= 8'h01 && a <= 8'h03) begin
        if (busy) e.err = 1'b1;
        else m_cfg[a[1:0]] = d;
      end else if (a == 8'h05) m_flags = m_flags & ~d[3:1];
      else if (d[0] && busy) e.err = 1'b1;
    end else begin
      if (a >= 8'h01 && a <= 8'h03) e.rd = m_cfg[a[1:0]];
      else if (a == 8'h04) e.rd = m_rdata;
      else if (a == 8'h05) e.rd = {4'b0000, m_flags, busy};
    end
    apb_q.push_back(e);
    apb_xfer(w, a, d);
  endtask

  task automatic idle_random();
    logic [7:0] a = 8'($urandom_range(0, 7));
    bit         w = 1'($urandom_range(0, 1));
    logic [7:0] d = 8'($urandom);
    if (w && a == 8'h00) d[0] = 1'b0;
    do_access(w, a, d, 1'b0);
  endtask

  task automatic busy_random();
    logic [7:0] a = 8'($urandom_range(0, 7));
    bit         w = 1'($urandom_range(0, 1));
    logic [7:0] d = 8'($urandom);
    if (a == 8'h04) w = 1'b1;
    do_access(w, a, d, 1'b1);
  endtask

  task automatic respond(input int delay, input bit tmo, input logic [7:0] resp, input bit rerr);
    int n = 0;
    while (!bus.i2c_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tmo) begin
      repeat (delay - 1) @(posedge clk);
      #1;
      bus.i2c_done = 1'b1; bus.i2c_rdata = resp; bus.i2c_err = rerr;
      @(posedge clk); #1;
      bus.i2c_done = 1'b0; bus.i2c_err = 1'b0; bus.i2c_rdata = 8'($urandom);
    end else begin
      n = 0;
      while (bus.i2c_req && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (2) @(posedge clk);
      #1;
      bus.i2c_done = 1'b1; bus.i2c_rdata = 8'($urandom); bus.i2c_err = 1'b1;
      @(posedge clk); #1;
      bus.i2c_done = 1'b0; bus.i2c_err = 1'b0;
    end
  endtask

  task automatic run_txn(input bit rw, input int delay, input bit tmo, input logic [7:0] resp,
                         input bit rerr, input int nbusy, input bit stall_rd);
    apb_exp_t   e;
    cmd_exp_t   c;
    logic [7:0] post_rd;
    logic [2:0] post_fl;
    int         n = 0;
    c.rw = rw; c.slv = m_cfg[1]; c.adr = m_cfg[2]; c.wd = m_cfg[3];
    c.len = tmo ? TMO : delay;
    cmd_q.push_back(c);
    e.is_rd = 1'b0; e.err = 1'b0; e.rd = 8'h00; e.stall = 1'b0;
    apb_q.push_back(e);
    apb_xfer(1'b1, 8'h00, {6'd0, rw, 1'b1});
    m_flags = 3'b000;
    post_rd = (rw && !tmo) ? resp : m_rdata;
    post_fl = tmo ? 3'b101 : {1'b0, rerr, 1'b1};
    fork
      respond(delay, tmo, resp, rerr);
      begin
        for (int i = 0; i < nbusy; i++) busy_random();
        if (stall_rd) begin
          e.is_rd = 1'b1; e.err = 1'b0; e.rd = post_rd; e.stall = 1'b1;
          apb_q.push_back(e);
          apb_xfer(1'b0, 8'h04, 8'h00);
        end
      end
    join
    m_rdata = post_rd;
    m_flags = post_fl;
    while (bus.i2c_req && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // APB monitor: pops one expectation per completed access.
  initial begin
    int       waits = 0;
    apb_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        waits = 0;
      end else if (bus.psel && bus.penable) begin
        if (!bus.pready) begin
          waits++;
        end else begin
          if (apb_q.size() == 0) begin
            fail("apb_unexpected_completion");
          end else begin
            e = apb_q.pop_front();
            check("pslverr", 32'(bus.pslverr), 32'(e.err));
            if (e.is_rd && !e.err) check("prdata", 32'(bus.prdata), 32'(e.rd));
            if (e.stall) check("stall_end_req", 32'(bus.i2c_req), 32'd0);
            else         check("wait_states", 32'(waits), 32'd0);
          end
          waits = 0;
        end
      end
    end
  end

  // I2C command monitor: checks command fields at request rise and request length.
  initial begin
    bit       prev = 1'b0;
    bit       have = 1'b0;
    int       len  = 0;
    cmd_exp_t c;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        have = 1'b0;
      end else begin
        if (bus.i2c_req && !prev) begin
          len = 1;
          if (cmd_q.size() == 0) begin
            fail("req_unexpected");
            have = 1'b0;
          end else begin
            c = cmd_q.pop_front();
            have = 1'b1;
            check("i2c_rw",    32'(bus.i2c_rw),    32'(c.rw));
            check("i2c_slave", 32'(bus.i2c_slave), 32'(c.slv));
            check("i2c_addr",  32'(bus.i2c_addr),  32'(c.adr));
            check("i2c_wdata", 32'(bus.i2c_wdata), 32'(c.wd));
          end
        end else if (bus.i2c_req) begin
          len++;
        end else if (prev && have && c.len != 0) begin
          check("req_len", 32'(len), 32'(c.len));
        end
        prev = bus.i2c_req;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_exp_t c;
    apb_exp_t e;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 8'h00; bus.pwdata = 8'h00;
    bus.i2c_done = 1'b0; bus.i2c_rdata = 8'h00; bus.i2c_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_i2c_req",   32'(bus.i2c_req),   32'd0);
    check("rst_i2c_rw",    32'(bus.i2c_rw),    32'd0);
    check("rst_i2c_slave", 32'(bus.i2c_slave), 32'd0);
    check("rst_i2c_addr",  32'(bus.i2c_addr),  32'd0);
    check("rst_i2c_wdata", 32'(bus.i2c_wdata), 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a <= 5; a++) do_access(1'b0, 8'(a), 8'h00, 1'b0);

    // I2C write with fixed configuration, 20-cycle completion
    do_access(1'b1, 8'h01, 8'h2A, 1'b0);
    do_access(1'b1, 8'h02, 8'h10, 1'b0);
    do_access(1'b1, 8'h03, 8'h5C, 1'b0);
    run_txn(1'b0, 20, 1'b0, 8'h00, 1'b0, 1, 1'b0);
    do_access(1'b0, 8'h05, 8'h00, 1'b0);
    // I2C read with a stalled RDATA read
    run_txn(1'b1, 15, 1'b0, 8'hA7, 1'b0, 0, 1'b1);
    do_access(1'b0, 8'h05, 8'h00, 1'b0);
    // NACK, then W1C
    run_txn(1'b0, 14, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_access(1'b0, 8'h05, 8'h00, 1'b0);
    do_access(1'b1, 8'h05, 8'h06, 1'b0);
    do_access(1'b0, 8'h05, 8'h00, 1'b0);
    // Illegal accesses
    do_access(1'b0, 8'h07, 8'h00, 1'b0);
    do_access(1'b1, 8'h04, 8'h33, 1'b0);
    do_access(1'b0, 8'h04, 8'h00, 1'b0);
    // Timeout followed by an ignored late completion
    run_txn(1'b1, 0, 1'b1, 8'h00, 1'b0, 2, 1'b1);
    do_access(1'b0, 8'h05, 8'h00, 1'b0);
    do_access(1'b0, 8'h04, 8'h00, 1'b0);

    for (int it = 0; it < 30; it++) begin
      int nidle = $urandom_range(1, 4);
      for (int k = 0; k < nidle; k++) idle_random();
      do_access(1'b0, 8'h05, 8'h00, 1'b0);
      run_txn(1'($urandom_range(0, 1)), $urandom_range(12, 23), ($urandom_range(0, 5) == 0),
              8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
      do_access(1'b0, 8'h05, 8'h00, 1'b0);
    end

    // Reset in the middle of a request
    do_access(1'b1, 8'h01, 8'h55, 1'b0);
    c.rw = 1'b0; c.slv = m_cfg[1]; c.adr = m_cfg[2]; c.wd = m_cfg[3]; c.len = 0;
    cmd_q.push_back(c);
    e.is_rd = 1'b0; e.err = 1'b0; e.rd = 8'h00; e.stall = 1'b0;
    apb_q.push_back(e);
    apb_xfer(1'b1, 8'h00, 8'h01);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(bus.i2c_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int a = 1; a <= 5; a++) do_access(1'b0, 8'(a), 8'h00, 1'b0);

    repeat (5) @(posedge clk);
    check("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
